// File: rtl/byte_pair_deser.sv
// Deserialises two MSB-first bit streams into a byte pair held in a
// valid/ready output register; a pair completing while the register is
// still occupied and not being accepted is dropped and flagged sticky.
module byte_pair_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       bit_valid,
    input  logic                       bit_a,
    input  logic                       bit_b,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           byte_a,
    output logic [WIDTH-1:0]           byte_b,
    output logic                       out_valid,
    output logic                       overrun,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             load_c;
    logic             drop_c;
    logic             last_bit_c;
    logic             accept_c;

    // Only WIDTH-1 bits are stored; the current bit completes the byte.
    logic [WIDTH-2:0] sh_a_q;
    logic [WIDTH-2:0] sh_b_q;
    logic [WIDTH-1:0] full_a_c;
    logic [WIDTH-1:0] full_b_c;

    assign full_a_c   = {sh_a_q, bit_a};
    assign full_b_c   = {sh_b_q, bit_b};
    assign last_bit_c = bit_valid && (bit_cnt == CW'(WIDTH - 1));
    assign out_valid  = (state_q == ST_FULL);
    assign accept_c   = out_valid && out_ready;

    // Output state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and load/drop decisions for the output register.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        drop_c  = 1'b0;
        if (clr) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (last_bit_c) begin
                        load_c  = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept_c && last_bit_c) begin
                        load_c = 1'b1;
                    end else if (accept_c) begin
                        state_d = ST_EMPTY;
                    end else if (last_bit_c) begin
                        drop_c = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Serial side: shift registers and bit counter, never stalled by the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            bit_cnt <= '0;
        end else if (bit_valid) begin
            sh_a_q  <= full_a_c[WIDTH-2:0];
            sh_b_q  <= full_b_c[WIDTH-2:0];
            bit_cnt <= last_bit_c ? '0 : bit_cnt + CW'(1);
        end
    end

    // Output byte registers and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_a  <= '0;
            byte_b  <= '0;
            overrun <= 1'b0;
        end else if (clr) begin
            byte_a  <= '0;
            byte_b  <= '0;
            overrun <= 1'b0;
        end else begin
            if (load_c) begin
                byte_a <= full_a_c;
                byte_b <= full_b_c;
            end
            if (drop_c) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byte_pair_deser.sv
// Bench for byte_pair_deser: directed pair table, hand-written reset/clear
// sequences, and a random run against a pair-level reference model.
module tb_byte_pair_deser;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             bit_valid;
    logic             bit_a;
    logic             bit_b;
    logic             out_ready;
    logic [WIDTH-1:0] byte_a;
    logic [WIDTH-1:0] byte_b;
    logic             out_valid;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    byte_pair_deser #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .bit_valid (bit_valid),
        .bit_a     (bit_a),
        .bit_b     (bit_b),
        .out_ready (out_ready),
        .byte_a    (byte_a),
        .byte_b    (byte_b),
        .out_valid (out_valid),
        .overrun   (overrun),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    // pre: bit0 = one idle accept cycle first, bit1 = one clr cycle first.
    typedef struct {
        logic [1:0]       pre;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               gap;
        logic             rdy;
        logic             rdy_last;
        logic             exp_v;
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;
        logic             exp_o;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic rdy);
        bit_valid = 1'b0;
        out_ready = rdy;
        step();
    endtask

    // Shifts a pair in MSB first, with 'gap' idle cycles after every bit but the last.
    task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input int gap, input logic rdy, input logic rdy_last);
        for (int i = 0; i < int'(WIDTH); i++) begin
            bit_valid = 1'b1;
            bit_a     = a[WIDTH-1-i];
            bit_b     = b[WIDTH-1-i];
            out_ready = (i == int'(WIDTH) - 1) ? rdy_last : rdy;
            step();
            if (i < int'(WIDTH) - 1) begin
                for (int g = 0; g < gap; g++) begin
                    bit_valid = 1'b0;
                    bit_a     = 1'($urandom);
                    bit_b     = 1'($urandom);
                    out_ready = rdy;
                    step();
                    chk("gap_cnt_hold", 32'(bit_cnt), 32'(i + 1));
                end
            end
        end
        bit_valid = 1'b0;
    endtask

    // Random-run reference model state.
    logic             m_hold;
    logic             m_ovr;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    int               bidx;
    int               pairs;
    int               m_acc;
    int               dut_acc;
    int               m_drop;

    initial begin
        tbl[0] = '{2'd0, 8'hA5, 8'h3C, 0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 1'b0};
        tbl[1] = '{2'd0, 8'hA5, 8'h3C, 2, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 1'b0};
        tbl[2] = '{2'd1, 8'h10, 8'h20, 0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h20, 1'b0};
        tbl[3] = '{2'd0, 8'h30, 8'h40, 1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h20, 1'b1};
        tbl[4] = '{2'd3, 8'h7F, 8'h80, 0, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b0};
        tbl[5] = '{2'd0, 8'h01, 8'hFE, 0, 1'b0, 1'b1, 1'b1, 8'h01, 8'hFE, 1'b0};

        rst_n     = 1'b0;
        clr       = 1'b0;
        bit_valid = 1'b0;
        bit_a     = 1'b0;
        bit_b     = 1'b0;
        out_ready = 1'b0;
        #7;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovr",   32'(overrun),   32'd0);
        chk("rst_cnt",   32'(bit_cnt),   32'd0);
        chk("rst_byte_a", 32'(byte_a),   32'd0);
        #5;
        rst_n = 1'b1;

        // Directed pair table.
        for (int r = 0; r < 6; r++) begin
            if (tbl[r].pre[0]) begin
                idle_cycle(1'b1);
                chk("pre_drain_valid", 32'(out_valid), 32'd0);
            end
            if (tbl[r].pre[1]) begin
                clr = 1'b1;
                idle_cycle(1'b0);
                clr = 1'b0;
                chk("pre_clr_ovr",   32'(overrun),   32'd0);
                chk("pre_clr_valid", 32'(out_valid), 32'd0);
                chk("pre_clr_cnt",   32'(bit_cnt),   32'd0);
            end
            send_pair(tbl[r].a, tbl[r].b, tbl[r].gap, tbl[r].rdy, tbl[r].rdy_last);
            chk($sformatf("row%0d_valid", r),  32'(out_valid), 32'(tbl[r].exp_v));
            chk($sformatf("row%0d_byte_a", r), 32'(byte_a),    32'(tbl[r].exp_a));
            chk($sformatf("row%0d_byte_b", r), 32'(byte_b),    32'(tbl[r].exp_b));
            chk($sformatf("row%0d_ovr", r),    32'(overrun),   32'(tbl[r].exp_o));
            chk($sformatf("row%0d_cnt", r),    32'(bit_cnt),   32'd0);
        end

        // Held pair stays stable while not accepted.
        idle_cycle(1'b0);
        chk("hold_valid",  32'(out_valid), 32'd1);
        chk("hold_byte_a", 32'(byte_a),    32'h01);

        // Async reset mid-pair: partial byte discarded, outputs cleared at once.
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            bit_a     = 1'b1;
            bit_b     = 1'b0;
            out_ready = 1'b0;
            step();
        end
        bit_valid = 1'b0;
        chk("mid_cnt", 32'(bit_cnt), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid",  32'(out_valid), 32'd0);
        chk("async_byte_a", 32'(byte_a),    32'd0);
        chk("async_byte_b", 32'(byte_b),    32'd0);
        chk("async_cnt",    32'(bit_cnt),   32'd0);
        chk("async_ovr",    32'(overrun),   32'd0);
        #2;
        rst_n = 1'b1;
        send_pair(8'hFF, 8'h00, 0, 1'b1, 1'b1);
        chk("post_rst_valid",  32'(out_valid), 32'd1);
        chk("post_rst_byte_a", 32'(byte_a),    32'hFF);
        chk("post_rst_byte_b", 32'(byte_b),    32'h00);

        // Random run against pair-level model.
        clr = 1'b1;
        idle_cycle(1'b0);
        clr = 1'b0;
        m_hold  = 1'b0;
        m_ovr   = 1'b0;
        m_a     = '0;
        m_b     = '0;
        cur_a   = WIDTH'($urandom);
        cur_b   = WIDTH'($urandom);
        bidx    = 0;
        pairs   = 0;
        m_acc   = 0;
        dut_acc = 0;
        m_drop  = 0;
        while (pairs < 1000) begin
            logic bv;
            logic rdy;
            logic accept;
            logic comp;
            bv  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 5);
            bit_valid = bv;
            bit_a     = bv ? cur_a[WIDTH-1-bidx] : 1'($urandom);
            bit_b     = bv ? cur_b[WIDTH-1-bidx] : 1'($urandom);
            out_ready = rdy;
            if (out_valid && rdy) dut_acc++;
            step();
            accept = m_hold && rdy;
            comp   = bv && (bidx == int'(WIDTH) - 1);
            if (accept) m_acc++;
            if (bv) bidx++;
            if (comp) begin
                if (!m_hold || accept) begin
                    m_hold = 1'b1;
                    m_a    = cur_a;
                    m_b    = cur_b;
                end else begin
                    m_ovr = 1'b1;
                    m_drop++;
                end
                pairs++;
                bidx  = 0;
                cur_a = WIDTH'($urandom);
                cur_b = WIDTH'($urandom);
            end else if (accept) begin
                m_hold = 1'b0;
            end
            chk("rnd_valid", 32'(out_valid), 32'(m_hold));
            chk("rnd_ovr",   32'(overrun),   32'(m_ovr));
            chk("rnd_cnt",   32'(bit_cnt),   32'(bidx));
            if (m_hold) begin
                chk("rnd_byte_a", 32'(byte_a), 32'(m_a));
                chk("rnd_byte_b", 32'(byte_b), 32'(m_b));
            end
        end
        bit_valid = 1'b0;
        chk("rnd_accept_count", 32'(dut_acc), 32'(m_acc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
